// File: rtl/system_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : system_multi_timer
// Purpose  : Bank of NUM_CH independent down-counting timers behind a simple
//            chipselect/write_n register slave. Each channel has a prescaler,
//            one-shot or continuous reload, a timeout flag with interrupt
//            enable, and a counter snapshot register.
//
// Ports    : clk           - sole clock, rising edge
//            reset         - asynchronous, active-high
//            address       - word address {channel, register[1:0]}
//            chipselect    - slave select
//            write_n       - active-low write strobe (qualified by chipselect)
//            writedata     - write data
//            readdata      - registered read data (one cycle after a read)
//            irq           - OR of per-channel (TO & ITO)
//            timeout_pulse - one-cycle pulse per channel on timeout
//
// Register map per channel (address[1:0]):
//            0 STATUS  : [0] TO, [1] RUN          (any write clears TO)
//            1 CONTROL : [0] ITO, [1] CONT, [2] START, [3] STOP, [15:8] PRESCALE
//            2 PERIOD  : [CNT_W-1:0]
//            3 SNAP    : write captures counter, read returns capture
//
// Revision : 1.0 - initial release
// ============================================================================
module system_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 99999
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NUM_CH)+1:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         timeout_pulse
);

  localparam int               c_aw         = $clog2(NUM_CH) + 2;
  // Channel field is at least one bit wide so a single-channel build still
  // has a legal select signal; it is tied to zero in that case.
  localparam int               c_ch_w       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int               c_num_slot   = 1 << c_ch_w;
  localparam logic [CNT_W-1:0] c_rst_period = RESET_PERIOD[CNT_W-1:0];

  localparam logic [1:0] c_reg_status  = 2'd0;
  localparam logic [1:0] c_reg_control = 2'd1;
  localparam logic [1:0] c_reg_period  = 2'd2;
  localparam logic [1:0] c_reg_snap    = 2'd3;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic [c_ch_w-1:0] w_ch;
  logic [1:0]        w_reg;
  logic              w_wr;
  logic              w_rd;

  assign w_reg = address[1:0];
  assign w_wr  = chipselect & ~write_n;
  assign w_rd  = chipselect &  write_n;

  generate
    if (NUM_CH > 1) begin : g_ch_field
      assign w_ch = address[c_aw-1:2];
    end else begin : g_ch_single
      assign w_ch = 1'b0;
    end
  endgenerate

  // Read value per decodable channel slot; slots beyond NUM_CH read as zero.
  logic [31:0]       w_rd_slot [c_num_slot];
  logic [NUM_CH-1:0] w_irq_ch;

  // --------------------------------------------------------------------------
  // Timer channels
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_period;
      logic [CNT_W-1:0] r_snap;
      logic [7:0]       r_pcnt;
      logic [7:0]       r_prescale;
      logic             r_run;
      logic             r_to;
      logic             r_ito;
      logic             r_cont;
      logic             r_load;   // counter reload pending after a PERIOD write
      logic             r_pulse;
      logic             w_sel_wr;
      logic             w_tick;
      logic             w_timeout;
      logic [31:0]      w_rd_val;

      assign w_sel_wr  = w_wr & (w_ch == c_ch_w'(gi));
      assign w_tick    = r_run & (r_pcnt == r_prescale);
      assign w_timeout = w_tick & (r_cnt == '0);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt      <= c_rst_period;
          r_period   <= c_rst_period;
          r_snap     <= '0;
          r_pcnt     <= '0;
          r_prescale <= '0;
          r_run      <= 1'b0;
          r_to       <= 1'b0;
          r_ito      <= 1'b0;
          r_cont     <= 1'b0;
          r_load     <= 1'b0;
          r_pulse    <= 1'b0;
        end else begin
          r_pulse <= 1'b0;

          // Counting. A pending reload always has RUN=0 (the PERIOD write
          // that raised it also cleared RUN), so it never races a tick.
          if (r_load) begin
            r_cnt  <= r_period;
            r_pcnt <= '0;
            r_load <= 1'b0;
          end else if (r_run) begin
            if (w_tick) begin
              r_pcnt <= '0;
              if (r_cnt == '0) begin
                r_cnt   <= r_period;
                r_to    <= 1'b1;
                r_pulse <= 1'b1;
                if (!r_cont) begin
                  r_run <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end else begin
              r_pcnt <= r_pcnt + 8'd1;
            end
          end

          // Register writes are evaluated after counting so that START/STOP
          // override a same-edge RUN change from a one-shot timeout.
          if (w_sel_wr) begin
            case (w_reg)
              c_reg_status: begin
                // A timeout on the same edge keeps TO set.
                if (!w_timeout) begin
                  r_to <= 1'b0;
                end
              end
              c_reg_control: begin
                r_ito      <= writedata[0];
                r_cont     <= writedata[1];
                r_prescale <= writedata[15:8];
                if (writedata[3]) begin
                  r_run <= 1'b0;
                end else if (writedata[2]) begin
                  r_run  <= 1'b1;
                  r_pcnt <= '0;
                end
              end
              c_reg_period: begin
                r_period <= writedata[CNT_W-1:0];
                r_run    <= 1'b0;
                r_load   <= 1'b1;
              end
              default: begin
                r_snap <= r_cnt;
              end
            endcase
          end
        end
      end

      always_comb begin
        w_rd_val = 32'd0;
        case (w_reg)
          c_reg_status:  w_rd_val = {30'd0, r_run, r_to};
          c_reg_control: w_rd_val = {16'd0, r_prescale, 6'd0, r_cont, r_ito};
          c_reg_period:  w_rd_val = 32'(r_period);
          default:       w_rd_val = 32'(r_snap);
        endcase
      end

      assign w_rd_slot[gi]     = w_rd_val;
      assign w_irq_ch[gi]      = r_to & r_ito;
      assign timeout_pulse[gi] = r_pulse;
    end

    for (gi = NUM_CH; gi < c_num_slot; gi++) begin : g_unmapped
      assign w_rd_slot[gi] = 32'd0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read data and interrupt
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (w_rd) begin
      readdata <= w_rd_slot[w_ch];
    end else begin
      readdata <= '0;
    end
  end

  assign irq = |w_irq_ch;

endmodule
`default_nettype wire
